// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the legality limit used to
// flag unsupported operations on the response path.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ADD  = 4'd0;
  localparam logic [OP_W-1:0] SUB  = 4'd1;
  localparam logic [OP_W-1:0] AND  = 4'd2;
  localparam logic [OP_W-1:0] OR   = 4'd3;
  localparam logic [OP_W-1:0] XOR  = 4'd4;
  localparam logic [OP_W-1:0] LUI  = 4'd5;
  localparam logic [OP_W-1:0] EQ   = 4'd6;
  localparam logic [OP_W-1:0] NE   = 4'd7;
  localparam logic [OP_W-1:0] GTU  = 4'd8;
  localparam logic [OP_W-1:0] LTU  = 4'd9;
  localparam logic [OP_W-1:0] GEU  = 4'd10;
  localparam logic [OP_W-1:0] LEU  = 4'd11;
  localparam logic [OP_W-1:0] SLT  = 4'd12;
  localparam logic [OP_W-1:0] SLTU = 4'd13;

  // Highest opcode the shared ALU implements; 14 and 15 are reported as errors.
  localparam logic [OP_W-1:0] OP_MAX_LEGAL = 4'd13;

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_MAX_LEGAL;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin grant: picks the first set request after the pointer, wrapping
// modulo NREQ. Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            gnt_valid_o
);

  // Walk the candidates ptr+1, ptr+2, ... ptr+NREQ and keep the first hit.
  always_comb begin
    logic [IDW-1:0] idx;
    logic           found;
    gnt_o       = '0;
    gnt_id_o    = '0;
    gnt_valid_o = 1'b0;
    found       = 1'b0;
    idx         = ptr_i;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters. A round-robin grant
// feeds an ISSUE register stage driving the ALU; the ALU result is captured in
// a RESP stage. Both stages advance independently so a response accept and a
// new grant in the same cycle keep the pipe full.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OP_W*NREQ-1:0] req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [31:0]          alu_data1,
  output logic [31:0]          alu_data2,
  output logic [OP_W-1:0]      alu_op,
  input  logic [31:0]          alu_out,
  output logic [NREQ-1:0]      resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  input  logic [NREQ-1:0]      resp_ready
);

  logic [OP_W-1:0] op_arr [NREQ];
  logic [31:0]     a_arr  [NREQ];
  logic [31:0]     b_arr  [NREQ];

  logic            issue_v_q, issue_v_d;
  logic [OP_W-1:0] issue_op_q, issue_op_d;
  logic [31:0]     issue_a_q, issue_a_d;
  logic [31:0]     issue_b_q, issue_b_d;
  logic [IDW-1:0]  issue_id_q, issue_id_d;

  logic            resp_v_q, resp_v_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;

  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            adv_resp;
  logic            adv_issue;
  logic            issue_err;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_arr[gi] = req_op[OP_W*gi +: OP_W];
      assign a_arr[gi]  = req_a[32*gi +: 32];
      assign b_arr[gi]  = req_b[32*gi +: 32];
    end
  endgenerate

  // A stage may take new data when it is empty or its occupant moves on.
  assign adv_resp  = !resp_v_q || resp_ready[resp_id_q];
  assign adv_issue = !issue_v_q || adv_resp;
  assign issue_err = op_illegal(issue_op_q);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .en_i        (adv_issue && !rst),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  assign req_ready = gnt;

  assign alu_data1 = issue_a_q;
  assign alu_data2 = issue_b_q;
  assign alu_op    = issue_op_q;

  assign resp_id   = resp_id_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_resp_valid
      assign resp_valid[gi] = resp_v_q && (resp_id_q == IDW'(gi));
    end
  endgenerate

  // Next-state for both pipeline stages and the round-robin pointer.
  always_comb begin
    issue_v_d   = issue_v_q;
    issue_op_d  = issue_op_q;
    issue_a_d   = issue_a_q;
    issue_b_d   = issue_b_q;
    issue_id_d  = issue_id_q;
    ptr_d       = ptr_q;
    resp_v_d    = resp_v_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    if (adv_issue) begin
      issue_v_d = gnt_valid;
      if (gnt_valid) begin
        issue_op_d = op_arr[gnt_id];
        issue_a_d  = a_arr[gnt_id];
        issue_b_d  = b_arr[gnt_id];
        issue_id_d = gnt_id;
        ptr_d      = gnt_id;
      end
    end

    // Unsupported opcodes never expose whatever the ALU drove for them.
    if (adv_resp) begin
      resp_v_d    = issue_v_q;
      resp_id_d   = issue_id_q;
      resp_err_d  = issue_err;
      resp_data_d = issue_err ? 32'd0 : alu_out;
    end
  end

  // State registers; reset discards anything in flight and restarts priority at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_v_q   <= 1'b0;
      issue_op_q  <= '0;
      issue_a_q   <= '0;
      issue_b_q   <= '0;
      issue_id_q  <= '0;
      ptr_q       <= IDW'(NREQ - 1);
      resp_v_q    <= 1'b0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      issue_v_q   <= issue_v_d;
      issue_op_q  <= issue_op_d;
      issue_a_q   <= issue_a_d;
      issue_b_q   <= issue_b_d;
      issue_id_q  <= issue_id_d;
      ptr_q       <= ptr_d;
      resp_v_q    <= resp_v_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a two-requester instance with a response scoreboard
// and a three-requester instance for the fairness scenario. A behavioural ALU
// closes the loop on alu_out.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Two-requester instance
  logic [1:0]  rv2, rr2, rsv2, rsr2;
  logic [7:0]  op2;
  logic [63:0] a2, b2;
  logic [31:0] d1_2, d2_2, ao2, rdata2;
  logic [3:0]  aop2;
  logic [0:0]  rid2;
  logic        rerr2;

  // Three-requester instance
  logic [2:0]  rv3, rr3, rsv3, rsr3;
  logic [11:0] op3;
  logic [95:0] a3, b3;
  logic [31:0] d1_3, d2_3, ao3, rdata3;
  logic [3:0]  aop3;
  logic [1:0]  rid3;
  logic        rerr3;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] pend_d [2];
  logic        pend_e [2];

  // Unsupported opcodes return a marker so forcing resp_data to zero is visible.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      LUI:     return b;
      EQ:      return {31'd0, a == b};
      NE:      return {31'd0, a != b};
      GTU:     return {31'd0, a > b};
      LTU:     return {31'd0, a < b};
      GEU:     return {31'd0, a >= b};
      LEU:     return {31'd0, a <= b};
      SLT:     return {31'd0, $signed(a) < $signed(b)};
      SLTU:    return {31'd0, a < b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign ao2 = alu_f(aop2, d1_2, d2_2);
  assign ao3 = alu_f(aop3, d1_3, d2_3);

  alu_arbiter #(.NREQ(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_ready(rr2), .req_op(op2),
    .req_a(a2), .req_b(b2), .alu_data1(d1_2), .alu_data2(d2_2), .alu_op(aop2),
    .alu_out(ao2), .resp_valid(rsv2), .resp_id(rid2), .resp_data(rdata2),
    .resp_err(rerr2), .resp_ready(rsr2)
  );

  alu_arbiter #(.NREQ(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3), .req_op(op3),
    .req_a(a3), .req_b(b3), .alu_data1(d1_3), .alu_data2(d2_3), .alu_op(aop3),
    .alu_out(ao3), .resp_valid(rsv3), .resp_id(rid3), .resp_data(rdata3),
    .resp_err(rerr3), .resp_ready(rsr3)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req2(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e);
    rv2[i]         = 1'b1;
    op2[4*i +: 4]  = op;
    a2[32*i +: 32] = a;
    b2[32*i +: 32] = b;
    pend_d[i]      = exp_d;
    pend_e[i]      = exp_e;
  endtask

  task automatic set_req3(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    rv3[i]         = 1'b1;
    op3[4*i +: 4]  = op;
    a3[32*i +: 32] = a;
    b3[32*i +: 32] = b;
  endtask

  // Wait (bounded) for every scoreboarded response to come back.
  task automatic drain();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Scoreboard: pop on a response handshake, push on a request handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if ((rsv2 & rsr2) != 2'b00) begin
        if (sb.size() == 0) begin
          check("spurious_resp", 32'(rsv2), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          $display("[TB] resp id=%0d data=%08h err=%0d", rid2, rdata2, rerr2);
          check("resp_id", 32'(rid2), 32'(mon_e.id));
          check("resp_data", rdata2, mon_e.data);
          check("resp_err", 32'(rerr2), 32'(mon_e.err));
          check("resp_valid_onehot", 32'(rsv2), 32'd1 << mon_e.id);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (rv2[i] && rr2[i]) sb.push_back('{i, pend_d[i], pend_e[i]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic found;
    rst  = 1'b1;
    rv2  = '0; op2 = '0; a2 = '0; b2 = '0; rsr2 = 2'b11;
    rv3  = '0; op3 = '0; a3 = '0; b3 = '0; rsr3 = 3'b111;
    pend_d[0] = '0; pend_d[1] = '0; pend_e[0] = 1'b0; pend_e[1] = 1'b0;
    tick(); tick();

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 32'(rr2), 32'd0);
    check("rst_resp_valid", 32'(rsv2), 32'd0);
    check("rst_resp_id", 32'(rid2), 32'd0);
    check("rst_resp_data", rdata2, 32'd0);
    check("rst_resp_err", 32'(rerr2), 32'd0);
    check("rst_alu_op", 32'(aop2), 32'd0);
    check("rst_alu_data1", d1_2, 32'd0);
    check("rst_alu_data2", d2_2, 32'd0);
    check("rst3_resp_valid", 32'(rsv3), 32'd0);
    tick();
    rst = 1'b0;

    // Single request: ADD 5+7
    set_req2(0, ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    @(negedge clk);
    check("single_gnt", 32'(rr2), 32'b01);
    tick();
    rv2[0] = 1'b0;
    @(negedge clk);
    check("single_issue_noresp", 32'(rsv2), 32'd0);
    check("single_alu_op", 32'(aop2), 32'(ADD));
    check("single_alu_data1", d1_2, 32'd5);
    check("single_alu_data2", d2_2, 32'd7);
    tick();
    @(negedge clk);
    check("single_resp_valid", 32'(rsv2), 32'b01);
    check("single_resp_id", 32'(rid2), 32'd0);
    check("single_resp_data", rdata2, 32'd12);
    tick();

    // Contention from a fresh reset: grants alternate 0,1,... with no bubbles
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req2(0, ADD, 32'd1000, 32'd1, 32'd1001, 1'b0);
    set_req2(1, SUB, 32'd50, 32'd8, 32'd42, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("cont_gnt", 32'(rr2), (k % 2 == 0) ? 32'b01 : 32'b10);
      if (k >= 2) check("cont_resp_valid", 32'(rsv2), (k % 2 == 0) ? 32'b01 : 32'b10);
      tick();
      if (k % 2 == 0) set_req2(0, ADD, 32'(k * 100), 32'(k), 32'(k * 101), 1'b0);
      else            set_req2(1, SUB, 32'(k * 100), 32'(k), 32'(k * 99), 1'b0);
    end
    rv2 = '0;
    drain();

    // Illegal opcode then a legal XOR
    set_req2(0, 4'd15, 32'd1, 32'd1, 32'd0, 1'b1);
    @(negedge clk);
    check("ill_gnt", 32'(rr2), 32'b01);
    tick();
    set_req2(0, XOR, 32'hF0, 32'hFF, 32'h0F, 1'b0);
    @(negedge clk);
    check("xor_gnt", 32'(rr2), 32'b01);
    tick();
    rv2[0] = 1'b0;
    @(negedge clk);
    check("ill_resp_err", 32'(rerr2), 32'd1);
    check("ill_resp_data", rdata2, 32'd0);
    tick();
    @(negedge clk);
    check("xor_resp_err", 32'(rerr2), 32'd0);
    check("xor_resp_data", rdata2, 32'h0F);
    tick();
    drain();

    // Backpressure: both stages fill, req0's next op waits for resp_ready[1]
    rsr2 = 2'b00;
    set_req2(1, SUB, 32'd10, 32'd3, 32'd7, 1'b0);
    set_req2(0, ADD, 32'd20, 32'd22, 32'd42, 1'b0);
    @(negedge clk);
    check("bp_gnt1", 32'(rr2), 32'b10);
    tick();
    rv2[1] = 1'b0;
    @(negedge clk);
    check("bp_gnt0", 32'(rr2), 32'b01);
    tick();
    set_req2(0, ADD, 32'd1, 32'd2, 32'd3, 1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("bp_full_ready", 32'(rr2), 32'd0);
      check("bp_resp_valid", 32'(rsv2), 32'b10);
      check("bp_resp_data", rdata2, 32'd7);
      tick();
    end
    rsr2 = 2'b10;
    @(negedge clk);
    check("bp_release_gnt", 32'(rr2), 32'b01);
    tick();
    rv2[0] = 1'b0;
    rsr2   = 2'b11;
    drain();

    // Reset with both stages valid; last grant was requester 1
    rsr2 = 2'b00;
    set_req2(1, AND, 32'hFF00, 32'h0FF0, 32'h0F00, 1'b0);
    @(negedge clk);
    check("mr_gnt1a", 32'(rr2), 32'b10);
    tick();
    set_req2(1, OR, 32'd1, 32'd2, 32'd3, 1'b0);
    @(negedge clk);
    check("mr_gnt1b", 32'(rr2), 32'b10);
    tick();
    set_req2(0, ADD, 32'd3, 32'd4, 32'd7, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("mr_ready_in_rst", 32'(rr2), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mr_resp_valid", 32'(rsv2), 32'd0);
    check("mr_alu_op", 32'(aop2), 32'd0);
    check("mr_alu_data1", d1_2, 32'd0);
    check("mr_first_gnt", 32'(rr2), 32'b01);
    tick();
    rv2  = '0;
    rsr2 = 2'b11;
    drain();

    // NREQ=3: req0/req2 always busy, req1 requests once
    set_req3(0, ADD, 32'd1, 32'd1);
    set_req3(2, ADD, 32'd2, 32'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("n3_gnt", 32'(rr3), (k % 2 == 0) ? 32'b001 : 32'b100);
      tick();
    end
    set_req3(1, SUB, 32'd9, 32'd4);
    n     = 0;
    found = 1'b0;
    while (!found && n < 3) begin
      @(negedge clk);
      n++;
      if (rr3[1]) found = 1'b1;
      tick();
    end
    check("n3_req1_granted", 32'(found), 32'd1);
    rv3[1] = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("n3_resp_valid", 32'(rsv3), 32'b010);
    check("n3_resp_id", 32'(rid3), 32'd1);
    check("n3_resp_data", rdata3, 32'd5);
    check("n3_resp_err", 32'(rerr3), 32'd0);
    tick();
    rv3 = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
